// File: rtl/icache.sv
// Direct-mapped instruction cache with one-word frames and a two-state miss FSM.
// Optional hit/miss statistics counters are built only when ICACHE_STATS_EN is defined.
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t            state_q, state_d;
    logic [31:0]       miss_addr_q, miss_addr_d;
    logic [SETS-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]  tag_mem [SETS];
    logic [31:0]       data_mem [SETS];

    logic [IDX_W-1:0]  req_idx, miss_idx;
    logic [TAG_W-1:0]  req_tag, miss_tag;
    logic              lookup_hit;
    logic              fill_en;
    logic [1:0]        unused_byte_offset;

    assign req_idx            = imemaddr[IDX_W+1:2];
    assign req_tag            = imemaddr[31:IDX_W+2];
    assign miss_idx           = miss_addr_q[IDX_W+1:2];
    assign miss_tag           = miss_addr_q[31:IDX_W+2];
    assign unused_byte_offset = imemaddr[1:0];

    assign lookup_hit = imemREN && valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign imemload   = data_mem[req_idx];

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        valid_d     = valid_q;
        ihit        = 1'b0;
        iREN        = 1'b0;
        iaddr       = 32'h0;
        fill_en     = 1'b0;
        case (state_q)
            IDLE: begin
                ihit = lookup_hit;
                if (imemREN && !lookup_hit) begin
                    state_d     = FETCH;
                    miss_addr_d = {imemaddr[31:2], 2'b00};
                end
            end
            FETCH: begin
                // The fill targets the latched address; datapath changes are ignored here.
                iREN  = 1'b1;
                iaddr = miss_addr_q;
                if (!iwait) begin
                    fill_en           = 1'b1;
                    valid_d[miss_idx] = 1'b1;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            miss_addr_q <= 32'h0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            valid_q     <= valid_d;
        end
    end

    // Tag/data storage carries no reset; the valid bits alone qualify contents.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic        miss_start;

    assign miss_start = (state_q == IDLE) && (state_d == FETCH);

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (ihit && (hit_count_q != 32'hFFFF_FFFF)) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if (miss_start && (miss_count_q != 32'hFFFF_FFFF)) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count_q  <= 32'h0;
            miss_count_q <= 32'h0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    assign hit_count  = 32'h0;
    assign miss_count = 32'h0;
`endif

endmodule
